// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, a read-valid strobe and threshold flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and the err_clr input.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL  = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [DATA_W-1:0] dout_reg;
  logic              rd_valid_reg;
  logic              rd_acc, wr_acc;

  // Flags decode the registered count only, so they never glitch within a cycle.
  assign empty        = (cnt_reg == '0);
  assign full         = (cnt_reg == CNT_MAX);
  assign almost_empty = (cnt_reg <= AE_LVL);
  assign almost_full  = (cnt_reg >= AF_LVL);
  assign fifo_cnt     = cnt_reg;
  assign data_out     = dout_reg;
  assign rd_valid     = rd_valid_reg;

  // At full a simultaneous read frees the slot; at empty the read is refused.
  assign rd_acc = rd && !empty;
  assign wr_acc = wr && (!full || rd);

  always_comb begin
    cnt_next = cnt_reg;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      dout_reg     <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      rd_valid_reg <= rd_acc;
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dout_reg   <= mem[rd_ptr_reg];
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg, underflow_reg;
  logic overflow_next, underflow_next;

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    overflow_next  = (overflow_reg  && !err_clr) || (wr && full && !rd);
    underflow_next = (underflow_reg && !err_clr) || (rd && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table, queue model and scoreboard on read data.
// Covers SYNC_FIFO_ERR_EN flags when the macro is defined for the build.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0, rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic [CW-1:0] fifo_cnt;
  logic          empty, full, almost_empty, almost_full;
`ifdef SYNC_FIFO_ERR_EN
  logic          err_clr = 1'b0;
  logic          overflow, underflow;
  bit            ov_m, un_m;
`endif

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(DEPTH-2), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_cnt(fifo_cnt),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            passed = 0;
  logic [DW-1:0] mq[$];   // model contents
  logic [DW-1:0] sb[$];   // expected words awaiting rd_valid
  logic [DW-1:0] last_dout = '0;

  typedef struct {
    logic          w, r;
    logic [DW-1:0] d;
    int            cnt;
    logic          e, f, ae, af, v;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    int n;
    bit ra, wa;
    @(negedge clk);
    wr = w; rd = r; data_in = d;
    n  = mq.size();
    ra = r && (n > 0);
    wa = w && ((n < DEPTH) || r);
`ifdef SYNC_FIFO_ERR_EN
    ov_m = (ov_m && !err_clr) || (w && (n == DEPTH) && !r);
    un_m = (un_m && !err_clr) || (r && (n == 0));
`endif
    if (ra) sb.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, ra});
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_rd_valid: got data_out %0h expected no read (t=%0t)", data_out, $time);
      end else begin
        last_dout = sb.pop_front();
        chk("data_out", {24'b0, data_out}, {24'b0, last_dout});
      end
    end else begin
      chk("data_out_hold", {24'b0, data_out}, {24'b0, last_dout});
    end
    n = mq.size();
    chk("fifo_cnt", {27'b0, fifo_cnt}, n);
    chk("flags", {28'b0, empty, full, almost_empty, almost_full},
        {28'b0, n == 0, n == DEPTH, n <= 2, n >= DEPTH - 2});
`ifdef SYNC_FIFO_ERR_EN
    chk("err_flags", {30'b0, overflow, underflow}, {30'b0, ov_m, un_m});
`endif
  endtask

  initial begin
    //          w     r     d      cnt  e     f     ae    af    v
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h44, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values before any clock edge.
    #1;
    chk("rst_cnt", {27'b0, fifo_cnt}, 0);
    chk("rst_flags", {28'b0, empty, full, almost_empty, almost_full}, 32'b1010);
    chk("rst_rd_valid", {31'b0, rd_valid}, 0);
    chk("rst_data_out", {24'b0, data_out}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_cnt", i), {27'b0, fifo_cnt}, tbl[i].cnt);
      chk($sformatf("vec%0d_flags", i), {27'b0, empty, full, almost_empty, almost_full, rd_valid},
          {27'b0, tbl[i].e, tbl[i].f, tbl[i].ae, tbl[i].af, tbl[i].v});
    end

    // Asynchronous reset mid-fill at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_cnt", {27'b0, fifo_cnt}, 0);
    chk("async_rst_empty", {31'b0, empty}, 1);
    chk("async_rst_data_out", {24'b0, data_out}, 0);
    mq.delete(); sb.delete(); last_dout = '0;
`ifdef SYNC_FIFO_ERR_EN
    chk("async_rst_err", {30'b0, overflow, underflow}, 0);
    ov_m = 0; un_m = 0;
`endif
    @(negedge clk);
    rst = 1'b1;

    // Fill to full; almost_full from count 14.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
`ifdef SYNC_FIFO_ERR_EN
    step(1'b1, 1'b0, 8'hEE);
    chk("overflow_set", {31'b0, overflow}, 1);
`endif
    // Simultaneous read/write at full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    chk("drained_empty", {31'b0, empty}, 1);
`ifdef SYNC_FIFO_ERR_EN
    step(1'b0, 1'b1, 8'h00);
    chk("underflow_set", {31'b0, underflow}, 1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    chk("err_clr", {30'b0, overflow, underflow}, 0);
`endif

    // Wrap-around past DEPTH-1.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO and the next generation of the team's 8x8 synchronous FIFO. It has configurable data width, depth and almost-full/almost-empty thresholds. It defines behaviour for simultaneous read/write at full and empty, gives a registered read-valid strobe, and can optionally carry sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and provides rate smoothing.

## Interface
- DATA_W, 8: data width in bits, at least 1
- DEPTH, 16: number of entries; power of 2, at least 2
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- wr  input  1  write request
- rd  input  1  read request
- data_in  input  DATA_W  write data, sampled on an accepted write
- data_out  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle pulse when data_out holds newly read data
- fifo_cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  fifo_cnt == 0
- full  output  1  fifo_cnt == DEPTH
- almost_empty  output  1  fifo_cnt <= AE_THRESH
- almost_full  output  1  fifo_cnt >= AF_THRESH
- overflow, underflow  output  1 each  sticky error flags (present only with SYNC_FIFO_ERR_EN)
- err_clr  input  1  clears the sticky flags (present only with SYNC_FIFO_ERR_EN)

## Operation
- Storage is a DEPTH x DATA_W array. rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- A read is accepted when rd && !empty.
- A write is accepted when wr && (!full || rd).
  - At full with rd && wr, both the read and the write are accepted. fifo_cnt stays at DEPTH.
  - At empty with rd && wr, only the write is accepted and the read is rejected. fifo_cnt becomes 1. This is not bypass: the written word is not output this cycle.
- fifo_cnt update:
  - +1 on a write only
  - -1 on a read only
  - unchanged when both are accepted or neither is
  - never wraps: it saturates by construction.
- The array is not reset. Contents are undefined until written.
- empty, full, almost_empty and almost_full are combinational decodes of the registered fifo_cnt, so they are glitch-free relative to clk.
- data_out holds its last value when no read is accepted.
- Rejected requests change no state other than the error flags.

## Timing
- Reset values (asynchronous, applied while rst = 0):
  - rd_ptr = 0, wr_ptr = 0, fifo_cnt = 0
  - data_out = 0, rd_valid = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - overflow = 0, underflow = 0
- Reset release is synchronous to the next rising edge. Asserting reset mid-transfer discards all contents immediately.
- Write to flag latency: an accepted write at edge N makes fifo_cnt, empty and the other flags reflect it after edge N.
- Read latency: a read accepted at edge N drives data_out = the oldest word and rd_valid = 1 during cycle N+1. rd_valid falls after one cycle unless another read is accepted.
- Back-to-back reads give one word per cycle, and rd_valid stays high throughout.
- Write-to-read: a word written at edge N can be read at edge N+1 at the earliest. Its data appears on data_out after edge N+1.
- Minimum reset pulse: none required; any low level resets the block.

## Configuration
- Macro SYNC_FIFO_ERR_EN.
- When defined, the overflow, underflow and err_clr ports exist.
  - overflow sets on any cycle with wr && full && !rd.
  - underflow sets on any cycle with rd && empty, including rd && wr at empty.
  - Both flags stay set until err_clr = 1 at a rising edge. If err_clr and a new error event occur in the same cycle, the set wins.
- When undefined, those ports are absent. Rejected requests are silently dropped and all other behaviour is identical.

## Test plan
- Reset then idle: empty = 1, almost_empty = 1, fifo_cnt = 0, data_out = 0, rd_valid = 0. Drive rst = 0 mid-fill at count 5: fifo_cnt reads 0 immediately, without waiting for a clock edge.
- Write 0x01..0x10 (DEPTH = 16): full = 1 after the 16th edge, and almost_full = 1 from count 14. Reading 16 times returns 0x01..0x10 in order, each with rd_valid = 1, then empty = 1.
- Wrap-around: write 12, read 12, then write 0x80..0x8B and read them back. The data is in order, and the pointers have wrapped past DEPTH-1.
- At full, hold rd = wr = 1 for 4 cycles with data 0xA0..0xA3: fifo_cnt stays 16, and the 4 oldest words appear on data_out. Then read the remaining words: the last 4 are 0xA0..0xA3.
- At empty, rd = wr = 1 with data 0x55: fifo_cnt = 1 and rd_valid = 0. The next read returns 0x55.
- With SYNC_FIFO_ERR_EN:
  - A write at full without rd sets overflow = 1, and fifo_cnt stays 16.
  - A read at empty sets underflow = 1.
  - err_clr = 1 clears both flags on the next edge.
